// File: rtl/funrv32_reg_bist.sv
// March-pattern BIST sequencer for the funrv32_reg register file: writes a seeded
// pattern, reads it back on both ports, repeats inverted, and reports the first mismatch.
//
// state   | meaning
// S_IDLE  | waiting for start after reset
// S_WRITE | writing P(k,ph) to register k
// S_READ  | reading k on port 1 and NREG-1-k on port 2
// S_DRAIN | waiting for the last READ_LAT compares of the phase
// S_FAIL  | mismatch latched, one cycle before DONE
// S_DONE  | result held until the next accepted start
module funrv32_reg_bist #(
  parameter int              XLEN     = 32,
  parameter int              NREG     = 32,
  parameter int              READ_LAT = 1,
  parameter logic [XLEN-1:0] SEED     = 32'hA5A5_0000
) (
  input  logic            clk,
  input  logic            resetb,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [4:0]      fail_addr,
  output logic            fail_port,
  output logic            bist_we,
  output logic [4:0]      bist_ad,
  output logic [XLEN-1:0] bist_rd,
  output logic [4:0]      bist_a1,
  output logic [4:0]      bist_a2,
  input  logic [XLEN-1:0] r1,
  input  logic [XLEN-1:0] r2
);

  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN, S_FAIL, S_DONE} state_t;

  localparam logic [4:0] K_LAST = 5'(NREG - 1);

  state_t          r_state, w_state_nxt;
  logic [4:0]      r_k, w_k_nxt;
  logic            r_ph, w_ph_nxt;
  logic            r_err;
  logic [4:0]      r_fail_addr;
  logic            r_fail_port;
  logic [4:0]      w_a2;
  logic            w_start_acc;
  logic            w_cmp_vld;
  logic [4:0]      w_cmp_a1, w_cmp_a2;
  logic [XLEN-1:0] w_exp1, w_exp2;
  logic            w_mis1, w_mis2, w_mis;

  function automatic logic [XLEN-1:0] f_pat(input logic [4:0] k, input logic ph);
    logic [XLEN-1:0] v;
    v = SEED + XLEN'(k) * XLEN'(32'h0101_0101);
    return v ^ {XLEN{ph}};
  endfunction

  // x0 is hardwired to zero in the register file, so its expected read is 0
  function automatic logic [XLEN-1:0] f_exp(input logic [4:0] k, input logic ph);
    return (k == 5'd0) ? '0 : f_pat(k, ph);
  endfunction

  assign w_a2        = K_LAST - r_k;
  assign w_start_acc = start && ((r_state == S_IDLE) || (r_state == S_DONE));

  generate
    if (READ_LAT == 0) begin : g_lat0
      assign w_cmp_vld = (r_state == S_READ);
      assign w_cmp_a1  = r_k;
      assign w_cmp_a2  = w_a2;
      assign w_exp1    = f_exp(r_k, r_ph);
      assign w_exp2    = f_exp(w_a2, r_ph);
    end else begin : g_lat1
      logic            r_vld;
      logic [4:0]      r_pa1, r_pa2;
      logic [XLEN-1:0] r_pe1, r_pe2;
      always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
          r_vld <= 1'b0;
          r_pa1 <= '0;
          r_pa2 <= '0;
          r_pe1 <= '0;
          r_pe2 <= '0;
        end else begin
          r_vld <= (r_state == S_READ);
          r_pa1 <= r_k;
          r_pa2 <= w_a2;
          r_pe1 <= f_exp(r_k, r_ph);
          r_pe2 <= f_exp(w_a2, r_ph);
        end
      end
      // the pipeline still holds a READ entry after a mismatch; only compare while testing
      assign w_cmp_vld = r_vld && ((r_state == S_READ) || (r_state == S_DRAIN));
      assign w_cmp_a1  = r_pa1;
      assign w_cmp_a2  = r_pa2;
      assign w_exp1    = r_pe1;
      assign w_exp2    = r_pe2;
    end
  endgenerate

  assign w_mis1 = w_cmp_vld && (r1 != w_exp1);
  assign w_mis2 = w_cmp_vld && (r2 != w_exp2);
  assign w_mis  = w_mis1 || w_mis2;

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      r_state     <= S_IDLE;
      r_k         <= '0;
      r_ph        <= 1'b0;
      r_err       <= 1'b0;
      r_fail_addr <= '0;
      r_fail_port <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_k     <= w_k_nxt;
      r_ph    <= w_ph_nxt;
      if (w_start_acc) begin
        r_err       <= 1'b0;
        r_fail_addr <= '0;
        r_fail_port <= 1'b0;
      end else if (w_mis) begin
        r_err       <= 1'b1;
        r_fail_port <= !w_mis1;
        r_fail_addr <= w_mis1 ? w_cmp_a1 : w_cmp_a2;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_k_nxt     = r_k;
    w_ph_nxt    = r_ph;
    bist_we     = 1'b0;
    bist_ad     = '0;
    bist_rd     = '0;
    bist_a1     = '0;
    bist_a2     = '0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_state_nxt = S_WRITE;
          w_k_nxt     = '0;
          w_ph_nxt    = 1'b0;
        end
      end
      S_WRITE: begin
        bist_we = 1'b1;
        bist_ad = r_k;
        bist_rd = f_pat(r_k, r_ph);
        w_k_nxt = r_k + 5'd1;
        if (r_k == K_LAST) begin
          w_k_nxt     = '0;
          w_state_nxt = S_READ;
        end
      end
      S_READ: begin
        bist_a1 = r_k;
        bist_a2 = w_a2;
        w_k_nxt = r_k + 5'd1;
        if (r_k == K_LAST) begin
          w_k_nxt = '0;
          if (READ_LAT == 0) begin
            w_state_nxt = r_ph ? S_DONE : S_WRITE;
            w_ph_nxt    = 1'b1;
          end else begin
            w_state_nxt = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        w_state_nxt = r_ph ? S_DONE : S_WRITE;
        w_ph_nxt    = 1'b1;
      end
      S_FAIL:  w_state_nxt = S_DONE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_mis) w_state_nxt = S_FAIL;
  end

  assign busy      = (r_state == S_WRITE) || (r_state == S_READ) ||
                     (r_state == S_DRAIN) || (r_state == S_FAIL);
  assign done      = (r_state == S_DONE);
  assign pass      = (r_state == S_DONE) && !r_err;
  assign fail_addr = r_fail_addr;
  assign fail_port = r_fail_port;

endmodule
